// File: rtl/segscan_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment scan decoder:
// segment patterns (a..g, active-low), anode slot codes and FSM states.
package segscan_decoder_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        COMPARE,
        CONVERT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    localparam logic [3:0] AN_UNITS     = 4'b0111;
    localparam logic [3:0] AN_TENS      = 4'b1110;
    localparam logic [3:0] AN_HUNDREDS  = 4'b1101;
    localparam logic [3:0] AN_THOUSANDS = 4'b1011;
    localparam logic [3:0] AN_IDLE      = 4'b1111;

    // Returns {hit, slot index}; slot 0 = units .. slot 3 = thousands.
    function automatic logic [2:0] an_to_slot(input logic [3:0] an_code);
        case (an_code)
            AN_UNITS:     return {1'b1, 2'd0};
            AN_TENS:      return {1'b1, 2'd1};
            AN_HUNDREDS:  return {1'b1, 2'd2};
            AN_THOUSANDS: return {1'b1, 2'd3};
            default:      return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/segscan_decoder_decode.sv
// Combinational segment-pattern to nibble lookup.
// Patterns A-F are accepted only when SEGSCAN_HEX_EN is defined.
module seg7_pattern_decode
    import segscan_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       ok
);

    always_comb begin
        nibble = 4'h0;
        ok     = 1'b1;
        case (pattern)
            SEG_0: nibble = 4'h0;
            SEG_1: nibble = 4'h1;
            SEG_2: nibble = 4'h2;
            SEG_3: nibble = 4'h3;
            SEG_4: nibble = 4'h4;
            SEG_5: nibble = 4'h5;
            SEG_6: nibble = 4'h6;
            SEG_7: nibble = 4'h7;
            SEG_8: nibble = 4'h8;
            SEG_9: nibble = 4'h9;
`ifdef SEGSCAN_HEX_EN
            SEG_A: nibble = 4'hA;
            SEG_B: nibble = 4'hB;
            SEG_C: nibble = 4'hC;
            SEG_D: nibble = 4'hD;
            SEG_E: nibble = 4'hE;
            SEG_F: nibble = 4'hF;
`endif
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/segscan_decoder.sv
// Recovers the displayed value from a scanned 4-digit 7-segment bus and publishes
// it once STABLE_FRAMES identical frames are seen. SEGSCAN_HEX_EN enables hex digits.
module segscan_decoder
    import segscan_decoder_pkg::*;
#(
    parameter int STABLE_FRAMES = 2
) (
    input  logic        myclk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [15:0] value,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    localparam int CW = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_FRAMES);
`ifdef SEGSCAN_HEX_EN
    localparam logic [15:0] BASE = 16'd16;
`else
    localparam logic [15:0] BASE = 16'd10;
`endif

    state_t        state;
    logic [3:0]    an_q;
    logic [15:0]   slots;
    logic [3:0]    seen;
    logic [15:0]   prev_frame;
    logic [15:0]   conv_frame;
    logic [15:0]   acc;
    logic [1:0]    conv_idx;
    logic [CW-1:0] match_cnt;

    logic [3:0]    dec_nibble;
    logic          dec_ok;
    logic [2:0]    slot_info;
    logic          slot_hit;
    logic [1:0]    slot_idx;
    logic [3:0]    seen_next;
    logic [CW-1:0] cnt_next;
    logic [3:0]    conv_nibble;
    logic          seg_dp_unused;

    // The decimal point carries no digit information.
    assign seg_dp_unused = seg[0];

    seg7_pattern_decode u_decode (
        .pattern (seg[7:1]),
        .nibble  (dec_nibble),
        .ok      (dec_ok)
    );

    // The segment bus settles one cycle after the anode select, so the current
    // seg is paired with the registered anode code.
    always_comb begin
        slot_info   = an_to_slot(an_q);
        slot_hit    = slot_info[2];
        slot_idx    = slot_info[1:0];
        seen_next   = seen | (4'b0001 << slot_idx);
        conv_nibble = conv_frame[{conv_idx, 2'b00} +: 4];
    end

    always_comb begin
        if (slots == prev_frame) begin
            if (match_cnt >= STABLE_MAX) begin
                cnt_next = STABLE_MAX;
            end else begin
                cnt_next = match_cnt + 1'b1;
            end
        end else begin
            cnt_next = CW'(1);
        end
    end

    always_ff @(posedge myclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            an_q       <= AN_IDLE;
            slots      <= '0;
            seen       <= '0;
            prev_frame <= '0;
            conv_frame <= '0;
            acc        <= '0;
            conv_idx   <= '0;
            match_cnt  <= '0;
            digits     <= '0;
            value      <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            an_q  <= an;
            valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (slot_hit) begin
                        if (!dec_ok) begin
                            err   <= 1'b1;
                            slots <= '0;
                            seen  <= '0;
                        end else begin
                            slots[{slot_idx, 2'b00} +: 4] <= dec_nibble;
                            seen <= seen_next;
                            if (&seen_next) begin
                                state <= COMPARE;
                            end
                        end
                    end
                end
                COMPARE: begin
                    match_cnt  <= cnt_next;
                    prev_frame <= slots;
                    seen       <= '0;
                    if ((cnt_next == STABLE_MAX) && (slots != digits)) begin
                        state      <= CONVERT;
                        busy       <= 1'b1;
                        conv_frame <= slots;
                        acc        <= '0;
                        conv_idx   <= 2'd3;
                    end else begin
                        state <= COLLECT;
                    end
                end
                CONVERT: begin
                    // Thousands first: acc = acc*base + digit over four cycles.
                    acc      <= acc * BASE + {12'd0, conv_nibble};
                    conv_idx <= conv_idx - 2'd1;
                    if (conv_idx == 2'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    digits <= conv_frame;
                    value  <= acc;
                    valid  <= 1'b1;
                    err    <= 1'b0;
                    state  <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: doc/segscan_decoder.md
SEGSCAN_DECODER -- requirements
Module: segscan_decoder

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 2: consecutive identical complete frames required before a value is published.
REQ-002 SHALL have port myclk, input, 1: single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port seg, input, 8: active-low segments; bit7..bit1 = a..g, bit0 = dp (ignored).
REQ-005 SHALL have port an, input, 4: active-low anode select.
REQ-006 SHALL have port digits, output, 16: last published BCD/hex nibbles; [3:0] units .. [15:12] thousands.
REQ-007 SHALL have port value, output, 16: binary value of digits.
REQ-008 SHALL have port valid, output, 1: one-cycle pulse when digits/value update.
REQ-009 SHALL have port err, output, 1: sticky flag for an undecodable segment pattern.
REQ-010 SHALL have port busy, output, 1: high in state CONVERT.

Function
REQ-011 SHALL pair the seg sample at cycle n+1 with the an sample at cycle n (one-cycle registered lag).
REQ-012 SHALL map an 0111 -> units, 1110 -> tens, 1101 -> hundreds, 1011 -> thousands; any other an code (including 1111 and multiple lows) SHALL be ignored for that slot.
REQ-013 SHALL decode seg[7:1]: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F.
REQ-014 SHALL treat an unlisted pattern as invalid: set err, discard the current frame, and return to COLLECT with all slots cleared.
REQ-015 SHALL implement FSM states COLLECT, COMPARE, CONVERT, DONE.
REQ-016 In COLLECT, SHALL store each decoded digit in its slot and set its slot-seen bit; a repeated slot overwrites; after all four bits are set -> COMPARE.
REQ-017 In COMPARE (one cycle), SHALL increment the match counter if the frame equals the previous frame, else load the counter with 1; the frame becomes the previous frame; slot-seen bits clear.
REQ-018 From COMPARE: counter = STABLE_FRAMES and frame differs from digits -> CONVERT; counter = STABLE_FRAMES and frame equals digits -> COLLECT with no valid; otherwise -> COLLECT.
REQ-019 The counter SHALL saturate at STABLE_FRAMES.
REQ-020 CONVERT SHALL take exactly 4 cycles, accumulating acc = acc*base + digit, thousands first; base = 10.
REQ-021 DONE (one cycle) SHALL update digits and value, pulse valid, clear err, -> COLLECT.
REQ-022 Inputs arriving during COMPARE/CONVERT/DONE SHALL be dropped; collection restarts with empty slots.
REQ-023 The frame-to-valid latency after the last digit of the qualifying frame is latched SHALL be 6 cycles.

Reset
REQ-024 rst_n low SHALL force, asynchronously: state COLLECT, digits 0, value 0, valid 0, err 0, busy 0, counter 0, slots and previous frame cleared, pipeline registers = idle (an 1111).
REQ-025 Reset asserted mid-CONVERT SHALL abandon the conversion with no valid pulse.

Configuration
REQ-026 With SEGSCAN_HEX_EN defined, SHALL accept A-F as digits and use base 16 in CONVERT.
REQ-027 Without SEGSCAN_HEX_EN, A-F SHALL be invalid per REQ-014, and the base SHALL be 10 (value max 9999).

Structure
REQ-028 The shared package SHALL hold the 16 segment pattern constants, the anode slot codes, and the FSM state typedef.
REQ-029 The pattern-to-nibble lookup SHALL be the sub-module seg7_pattern_decode (combinational; outputs nibble, ok).

Verification
REQ-030 Scan 0437 (encoder timing, 1-cycle lag), STABLE_FRAMES=2 -> single valid pulse; digits=16'h0437, value=437.
REQ-031 Hold 0437 for a further 10 frames -> no further valid pulse.
REQ-032 Inject seg=11111111 in the tens slot -> err=1; frame discarded; next good distinct stable value -> err=0, valid.
REQ-033 Alternate 0012 and 0013 every frame -> no valid pulse.
REQ-034 Drive an=1111 and an=0011 slots interleaved with a valid scan of 9999 -> ignored; value=9999.
REQ-035 Assert rst_n low on the second CONVERT cycle -> no valid pulse; all outputs 0. Without SEGSCAN_HEX_EN, scan A123 -> err=1. With SEGSCAN_HEX_EN, scan A123 -> value=16'hA123.
